// File: rtl/seq_detector_param_if.sv
// Bundles the serial-detector stream, configuration and result signals.
// master drives the stream and config inputs; slave is the detector side.
interface seq_detector_param_if #(
    parameter int PATTERN_W = 3,
    parameter int CNT_W     = 8
);
    logic                 x;
    logic                 x_valid;
    logic                 overlap_en;
    logic                 clear;
    logic                 cfg_load;
    logic [PATTERN_W-1:0] cfg_pattern;
    logic                 y;
    logic [CNT_W-1:0]     match_count;

    // x is consumed only on edges with x_valid=1 (no back-pressure).
    // cfg_load and clear are single-edge commands; y is a one-cycle pulse.
    modport master (
        output x, x_valid, overlap_en, clear, cfg_load, cfg_pattern,
        input  y, match_count
    );

    modport slave (
        input  x, x_valid, overlap_en, clear, cfg_load, cfg_pattern,
        output y, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial-pattern detector: compares the last PATTERN_W valid bits
// against a loadable pattern, with overlap control and a saturating hit counter.
module seq_detector_param #(
    parameter int                   PATTERN_W       = 3,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(3'b101),
    parameter int                   CNT_W           = 8
) (
    input logic                clk,
    input logic                reset_n,
    seq_detector_param_if.slave bus
);
    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] r_pattern;
    logic [PATTERN_W-1:0] r_hist;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_y;
    logic [CNT_W-1:0]     r_count;

    logic [PATTERN_W-1:0] w_pattern_n;
    logic [PATTERN_W-1:0] w_hist_n;
    logic [FILL_W-1:0]    w_fill_n;
    logic                 w_y_n;
    logic [CNT_W-1:0]     w_count_n;

    logic [PATTERN_W-1:0] w_hist_sh;
    logic [FILL_W-1:0]    w_fill_inc;
    logic                 w_hit;

    assign w_hist_sh  = {r_hist[PATTERN_W-2:0], bus.x};
    assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    // fill gating keeps reset/clear zeros from matching an all-zero pattern
    assign w_hit      = (w_fill_inc == FILL_MAX) && (w_hist_sh == r_pattern);

    always_comb begin
        w_pattern_n = r_pattern;
        w_hist_n    = r_hist;
        w_fill_n    = r_fill;
        w_y_n       = 1'b0;
        w_count_n   = r_count;
        if (bus.cfg_load) begin
            w_pattern_n = bus.cfg_pattern;
            w_fill_n    = '0;
        end else if (bus.clear) begin
            w_hist_n  = '0;
            w_fill_n  = '0;
            w_count_n = '0;
        end else if (bus.x_valid) begin
            w_hist_n = w_hist_sh;
            w_y_n    = w_hit;
            if (w_hit) begin
                if (r_count != '1) w_count_n = r_count + 1'b1;
                // non-overlapping search restarts from an empty window
                w_fill_n = bus.overlap_en ? FILL_MAX : '0;
            end else begin
                w_fill_n = w_fill_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= DEFAULT_PATTERN;
            r_hist    <= '0;
            r_fill    <= '0;
            r_y       <= 1'b0;
            r_count   <= '0;
        end else begin
            r_pattern <= w_pattern_n;
            r_hist    <= w_hist_n;
            r_fill    <= w_fill_n;
            r_y       <= w_y_n;
            r_count   <= w_count_n;
        end
    end

    assign bus.y           = r_y;
    assign bus.match_count = r_count;
endmodule

// File: tb/tb_seq_detector_param.sv
// Checks three detector configurations (W=3/CNT=8, W=4/CNT=8, W=3/CNT=2)
// against a bit-stream reference model, with directed and random stimulus.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PATTERN_W(3), .CNT_W(8)) if0 ();
  seq_detector_param_if #(.PATTERN_W(4), .CNT_W(8)) if1 ();
  seq_detector_param_if #(.PATTERN_W(3), .CNT_W(2)) if2 ();

  seq_detector_param #(.PATTERN_W(3), .CNT_W(8)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  seq_detector_param #(.PATTERN_W(4), .CNT_W(8)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  seq_detector_param #(.PATTERN_W(3), .CNT_W(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  int n_tests = 0;
  int n_fail = 0;

  // reference model: every bit since the last flush, as a growing value
  int          m_w[3]    = '{3, 4, 3};
  int          m_max[3]  = '{255, 255, 3};
  logic [63:0] m_hist[3];
  int          m_fresh[3];
  logic [31:0] m_pat[3];
  int          m_cnt[3];
  bit          m_y[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = '0; m_fresh[k] = 0; m_cnt[k] = 0; m_y[k] = 1'b0;
      m_pat[k] = 32'h5;
    end
  endfunction

  function automatic void model_edge(input int d, input bit xv, input bit xb, input bit ov,
                                     input bit clr, input bit ld, input logic [31:0] pat);
    logic [63:0] mask;
    mask = (64'd1 << m_w[d]) - 64'd1;
    m_y[d] = 1'b0;
    if (ld) begin
      m_pat[d] = pat & mask[31:0];
      m_fresh[d] = 0;
    end else if (clr) begin
      m_hist[d] = '0; m_fresh[d] = 0; m_cnt[d] = 0;
    end else if (xv) begin
      m_hist[d] = (m_hist[d] << 1) | {63'd0, xb};
      m_fresh[d]++;
      if (m_fresh[d] >= m_w[d] && (m_hist[d] & mask) == {32'd0, m_pat[d]}) begin
        m_y[d] = 1'b1;
        if (m_cnt[d] < m_max[d]) m_cnt[d]++;
        if (!ov) m_fresh[d] = 0;
      end
    end
  endfunction

  function automatic logic [31:0] get_y(input int d);
    case (d)
      0: return {31'd0, if0.y};
      1: return {31'd0, if1.y};
      default: return {31'd0, if2.y};
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int d);
    case (d)
      0: return 32'(if0.match_count);
      1: return 32'(if1.match_count);
      default: return 32'(if2.match_count);
    endcase
  endfunction

  task automatic idle_all();
    if0.x = 0; if0.x_valid = 0; if0.overlap_en = 0; if0.clear = 0; if0.cfg_load = 0; if0.cfg_pattern = '0;
    if1.x = 0; if1.x_valid = 0; if1.overlap_en = 0; if1.clear = 0; if1.cfg_load = 0; if1.cfg_pattern = '0;
    if2.x = 0; if2.x_valid = 0; if2.overlap_en = 0; if2.clear = 0; if2.cfg_load = 0; if2.cfg_pattern = '0;
  endtask

  // drive one edge on DUT d (others idle), advance the model, check y/count
  task automatic step(input int d, input bit xv, input bit xb, input bit ov, input bit clr,
                      input bit ld, input logic [31:0] pat, input string tag);
    idle_all();
    case (d)
      0: begin if0.x = xb; if0.x_valid = xv; if0.overlap_en = ov; if0.clear = clr;
               if0.cfg_load = ld; if0.cfg_pattern = pat[2:0]; end
      1: begin if1.x = xb; if1.x_valid = xv; if1.overlap_en = ov; if1.clear = clr;
               if1.cfg_load = ld; if1.cfg_pattern = pat[3:0]; end
      default: begin if2.x = xb; if2.x_valid = xv; if2.overlap_en = ov; if2.clear = clr;
               if2.cfg_load = ld; if2.cfg_pattern = pat[2:0]; end
    endcase
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k == d) model_edge(k, xv, xb, ov, clr, ld, pat);
      else model_edge(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    end
    #1;
    chk({tag, "_y"}, get_y(d), {31'd0, m_y[d]});
    chk({tag, "_cnt"}, get_cnt(d), 32'(m_cnt[d]));
  endtask

  task automatic bit_in(input int d, input bit xb, input bit ov, input string tag);
    step(d, 1'b1, xb, ov, 1'b0, 1'b0, 32'd0, tag);
  endtask

  task automatic do_clear(input int d);
    step(d, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, "clear");
  endtask

  initial begin
    logic [10:0] s_alt;
    logic [6:0]  s_w4;
    int          exp_sat[5];
    int          k;
    s_alt = 11'b10101010101;
    s_w4  = 7'b1101101;
    exp_sat = '{1, 2, 3, 3, 3};

    idle_all();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_y", get_y(d), 32'd0);
      chk("rst_cnt", get_cnt(d), 32'd0);
    end
    reset_n = 1'b1;

    // overlapping 1,0,1,0,1 -> hits on bits 3 and 5
    for (int i = 4; i >= 0; i--) bit_in(0, s_alt[i], 1'b1, "ovl");
    chk("ovl_total", get_cnt(0), 32'd2);

    // non-overlapping: only bit 3 hits, then a fresh 1,0,1 completes at bit 7
    do_clear(0);
    for (int i = 4; i >= 0; i--) bit_in(0, s_alt[i], 1'b0, "novl");
    chk("novl_total", get_cnt(0), 32'd1);
    bit_in(0, 1'b0, 1'b0, "novl_tail");
    bit_in(0, 1'b1, 1'b0, "novl_tail");
    chk("novl_fresh", get_cnt(0), 32'd2);

    // valid bits separated by idle cycles
    do_clear(0);
    for (int i = 2; i >= 0; i--) begin
      bit_in(0, s_alt[i], 1'b1, "gap_bit");
      if (i != 0)
        for (int j = 0; j < 3; j++) step(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, "gap_idle");
    end
    chk("gap_total", get_cnt(0), 32'd1);

    // W=4: load 1101 mid-fill; the following bits must refill the window
    bit_in(1, 1'b1, 1'b1, "w4_pre");
    bit_in(1, 1'b1, 1'b1, "w4_pre");
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hD, "w4_load");
    chk("w4_load_y", get_y(1), 32'd0);
    bit_in(1, 1'b1, 1'b1, "w4_refill");
    bit_in(1, 1'b1, 1'b1, "w4_refill");
    bit_in(1, 1'b0, 1'b1, "w4_refill");
    chk("w4_refill_cnt", get_cnt(1), 32'd0);
    bit_in(1, 1'b1, 1'b1, "w4_first");
    chk("w4_first_cnt", get_cnt(1), 32'd1);
    do_clear(1);
    for (int i = 3; i >= 0; i--) bit_in(1, s_w4[i + 3], 1'b1, "w4_one");
    chk("w4_one_cnt", get_cnt(1), 32'd1);
    for (int i = 6; i >= 0; i--) bit_in(1, s_w4[i], 1'b1, "w4_two");
    chk("w4_two_cnt", get_cnt(1), 32'd3);

    // CNT_W=2 saturation
    k = 0;
    for (int i = 10; i >= 0; i--) begin
      bit_in(2, s_alt[i], 1'b1, "sat");
      if (i % 2 == 0 && i <= 8) begin
        chk("sat_seq", get_cnt(2), 32'(exp_sat[k]));
        k++;
      end
    end
    do_clear(2);
    chk("sat_clr_cnt", get_cnt(2), 32'd0);
    chk("sat_clr_y", get_y(2), 32'd0);

    // asynchronous reset mid-pattern
    bit_in(0, 1'b1, 1'b1, "arst_pre");
    bit_in(0, 1'b0, 1'b1, "arst_pre");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_y", get_y(0), 32'd0);
    chk("arst_cnt", get_cnt(0), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bit_in(0, 1'b1, 1'b1, "arst_post");
    bit_in(0, 1'b1, 1'b1, "arst_post");
    bit_in(0, 1'b0, 1'b1, "arst_post");
    bit_in(0, 1'b1, 1'b1, "arst_post");
    chk("arst_post_cnt", get_cnt(0), 32'd1);

    // random traffic on each configuration
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 400; i++) begin
        step(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 40) == 0), ($urandom_range(0, 30) == 0), $urandom, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, programmable serial-pattern detector; successor to the fixed 3-bit "101" Moore detectors in the fsms library.
- Samples a qualified serial bit stream and compares the last PATTERN_W bits against a run-time loadable pattern.
- Supports overlapping and non-overlapping detection and keeps a saturating match counter.
- Intended for framing/sync-word search ahead of the serial-protocol blocks.

Parameters:
- PATTERN_W, 3, pattern length in bits (legal range 2..32).
- DEFAULT_PATTERN, 3'b101 (width PATTERN_W), pattern register value after reset.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only on edges where x_valid=1.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every edge.
- clear  input  1  synchronous flush of history and counter.
- cfg_load  input  1  load cfg_pattern into the pattern register.
- cfg_pattern  input  PATTERN_W  new pattern; the MSB is the oldest bit.
- y  output  1  registered Moore match flag.
- match_count  output  CNT_W  number of matches since reset or clear, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pattern_reg=DEFAULT_PATTERN, history=0, fill=0, y=0, match_count=0.
  - Deassertion is synchronous to clk. The first sampled bit is on the first edge with reset_n=1.
- Internal state:
  - history[PATTERN_W-1:0] is a shift register; the newest bit goes in the LSB.
  - fill is a 0..PATTERN_W count of valid bits held in history.
  - pattern_reg holds the active pattern.
- Priority per edge: cfg_load > clear > x_valid > idle.
- cfg_load=1:
  - pattern_reg<=cfg_pattern, fill<=0, y<=0.
  - match_count is unchanged.
  - Any x_valid bit on the same edge is discarded.
- clear=1 (no cfg_load): fill<=0, history<=0, y<=0, match_count<=0. Any x_valid bit is discarded.
- x_valid=1 (no cfg_load or clear):
  - hist_n = {history[PATTERN_W-2:0], x}.
  - fill_n = min(fill+1, PATTERN_W).
  - hit = (fill_n==PATTERN_W) && (hist_n==pattern_reg).
  - history<=hist_n and y<=hit.
  - If hit, match_count<=match_count+1, holding at 2^CNT_W-1 (no wrap).
  - If hit and overlap_en=1: fill<=PATTERN_W. The next bit can complete a match sharing bits with this one.
  - If hit and overlap_en=0: fill<=0. The next match needs PATTERN_W fresh bits.
  - If no hit: fill<=fill_n.
- x_valid=0 (idle): history, fill and match_count hold; y<=0.
- Latency and output timing:
  - y rises on the edge that samples the completing bit and is high for exactly one cycle per match.
  - Back-to-back matches (overlap, or PATTERN_W=1-step periodicity) keep y high on consecutive cycles.
  - match_count updates on the same edge as y.
- y and match_count are pure register outputs with no combinational path from inputs.
- overlap_en changes take effect on the next hit evaluated.
- An all-zero pattern is legal. It cannot match until fill reaches PATTERN_W; zeros present after reset or clear do not count.

Test Plan:
- Defaults, overlap_en=1, x_valid=1, stream 1,0,1,0,1 → y=1 the cycle after bits 3 and 5 only; match_count=2.
- Same stream with overlap_en=0 → y=1 only after bit 3; a fresh 1,0,1 is needed afterwards; match_count=1.
- Stream 1,0,1 with x_valid low for 3 idle cycles between each bit → y=1 once after the third valid bit; y=0 on all idle cycles.
- PATTERN_W=4: cfg_load with cfg_pattern=4'b1101 while fill=2 → y=0 and the next 3 bits are ignored for matching. Then 1,1,0,1 → one match; 1,1,0,1,1,0,1 with overlap → two matches.
- CNT_W=2: 5 matches → match_count sequence 1,2,3,3,3; then clear → match_count=0, y=0.
- Assert reset_n low mid-pattern (after 1,0), between edges → y=0 and match_count=0 immediately. After release, 1 then 1,0,1 yields exactly one match, with no carry-over of the old bits.
